row_arb_cam: RTL and testbench

Row arbiter CAM stage directly downstream of the entry buffer. It takes UI and Data Handler look-up requests and matches each request key (prio, row, bank) against a small CAM of open-row slots. It acknowledges a request when a slot can take the packet, then forwards the packet tagged with its slot index to the per-slot command queues. Slot occupancy is tracked per slot and returned via release pulses from the command scheduler.

---
 rtl/row_arb_cam.sv | 202 ++++++++++++++++++++
 tb/tb_row_arb_cam.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_arb_cam.sv
// -----------------------------------------------------------------------------
// row_arb_cam: row arbiter CAM stage that sits after the entry buffer.
//
// Each cycle the stage picks one look-up request. A Data Handler retry
// (intf_*) always wins over a UI request (ui_*). The winning key
// {prio, row, bank} is matched against a small CAM of open-row slots:
//   - hit : the request is accepted while the slot has fewer than SLOT_DEPTH
//           packets outstanding.
//   - miss: the lowest free slot is allocated for the key.
// The ack is combinational. In the following cycle the packet supplied on
// entry_pkt is forwarded, tagged with its slot index and an "opened new row"
// flag. The command scheduler retires packets per slot with release pulses.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ui_pkt_req  / ui_*       UI look-up request and key
//   intf_pkt_req / intf_*    Data Handler retry request and key (strict priority)
//   ui_pkt_ack, intf_pkt_ack same-cycle acceptance
//   entry_pkt                packet for the request acked in the previous cycle
//   out_pkt/out_valid/out_slot/out_new  forwarded packet beat
//   rel_valid, rel_slot      one packet of rel_slot retired
//   slots_used               number of valid slots (registered)
//   rel_err                  sticky flag for a release on an empty slot
// -----------------------------------------------------------------------------
package row_arb_cam_pkg;
  localparam int PRIO           = 4;
  localparam int ROW_ADDR_WIDTH = 14;
  localparam int BK_ADDR_WIDTH  = 3;
  localparam int PRIO_W         = (PRIO > 1) ? $clog2(PRIO) : 1;

  typedef logic [31:0] pkt_t;

  typedef struct packed {
    logic [PRIO_W-1:0]         prio;
    logic [ROW_ADDR_WIDTH-1:0] row;
    logic [BK_ADDR_WIDTH-1:0]  bk;
  } key_t;
endpackage

module row_arb_cam
  import row_arb_cam_pkg::*;
#(
  parameter int SLOTS      = 8,
  parameter int SLOT_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ui_pkt_req,
  input  logic [PRIO_W-1:0]          ui_prio,
  input  logic [ROW_ADDR_WIDTH-1:0]  ui_row_addr,
  input  logic [BK_ADDR_WIDTH-1:0]   ui_bk_addr,
  input  logic                       intf_pkt_req,
  input  logic [PRIO_W-1:0]          intf_prio,
  input  logic [ROW_ADDR_WIDTH-1:0]  intf_row_addr,
  input  logic [BK_ADDR_WIDTH-1:0]   intf_bk_addr,
  output logic                       ui_pkt_ack,
  output logic                       intf_pkt_ack,
  input  pkt_t                       entry_pkt,
  output pkt_t                       out_pkt,
  output logic                       out_valid,
  output logic [$clog2(SLOTS)-1:0]   out_slot,
  output logic                       out_new,
  input  logic                       rel_valid,
  input  logic [$clog2(SLOTS)-1:0]   rel_slot,
  output logic [$clog2(SLOTS):0]     slots_used,
  output logic                       rel_err
);

  localparam int SW = $clog2(SLOTS);
  localparam int CW = $clog2(SLOT_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(SLOT_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Slot state
  logic [SLOTS-1:0] vld_q, vld_d;
  key_t             key_q [SLOTS];
  key_t             key_d [SLOTS];
  logic [CW-1:0]    cnt_q [SLOTS];
  logic [CW-1:0]    cnt_d [SLOTS];

  // Forward stage and status registers
  logic          out_valid_q;
  logic [SW-1:0] out_slot_q;
  logic          out_new_q;
  logic [SW:0]   slots_used_q;
  logic          rel_err_q, rel_err_d;

  // Look-up results
  logic          win_req_s;
  key_t          win_key_s;
  logic          hit_any_s;
  logic [SW-1:0] hit_idx_s;
  logic          free_any_s;
  logic [SW-1:0] free_idx_s;
  logic          room_s;
  logic          accept_s;
  logic [SW-1:0] acc_idx_s;
  logic          rel_ok_s;

  function automatic logic [SW:0] popcount(input logic [SLOTS-1:0] v);
    logic [SW:0] n;
    n = '0;
    for (int i = 0; i < SLOTS; i++) begin
      n = n + (SW+1)'(v[i]);
    end
    return n;
  endfunction

  // Winner selection and CAM search against the slot state at the start of the cycle
  always_comb begin
    win_req_s  = intf_pkt_req | ui_pkt_req;
    win_key_s  = intf_pkt_req ? key_t'{prio: intf_prio, row: intf_row_addr, bk: intf_bk_addr}
                              : key_t'{prio: ui_prio,   row: ui_row_addr,   bk: ui_bk_addr};
    hit_any_s  = 1'b0;
    hit_idx_s  = '0;
    free_any_s = 1'b0;
    free_idx_s = '0;
    // Scan downwards so the lowest matching / free index is the one kept.
    // A slot freed by a release this cycle is still vld here, so a miss
    // cannot take it until the next cycle.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      hit_idx_s  = (vld_q[i] && (key_q[i] == win_key_s)) ? SW'(i) : hit_idx_s;
      hit_any_s  = hit_any_s | (vld_q[i] & (key_q[i] == win_key_s));
      free_idx_s = vld_q[i] ? free_idx_s : SW'(i);
      free_any_s = free_any_s | ~vld_q[i];
    end
    room_s    = hit_any_s ? (cnt_q[hit_idx_s] < DEPTH_C) : free_any_s;
    accept_s  = win_req_s & room_s & ~rst;
    acc_idx_s = hit_any_s ? hit_idx_s : free_idx_s;
  end

  assign intf_pkt_ack = accept_s & intf_pkt_req;
  assign ui_pkt_ack   = accept_s & ~intf_pkt_req;

  // Next slot state from this cycle's accept and release
  always_comb begin
    rel_ok_s  = rel_valid & vld_q[rel_slot] & (cnt_q[rel_slot] != '0);
    rel_err_d = rel_err_q | (rel_valid & ~rel_ok_s);
    for (int i = 0; i < SLOTS; i++) begin
      logic inc_s;
      logic dec_s;
      inc_s    = accept_s & (acc_idx_s == SW'(i));
      dec_s    = rel_ok_s & (rel_slot == SW'(i));
      vld_d[i] = vld_q[i];
      key_d[i] = key_q[i];
      cnt_d[i] = cnt_q[i];
      if (inc_s && !hit_any_s) begin
        // Allocation: the slot was invalid, so no valid release can target it.
        vld_d[i] = 1'b1;
        key_d[i] = win_key_s;
        cnt_d[i] = ONE_C;
      end else if (inc_s && dec_s) begin
        // Hit and retire together cancel out; the slot stays open.
        cnt_d[i] = cnt_q[i];
      end else if (inc_s) begin
        cnt_d[i] = cnt_q[i] + ONE_C;
      end else if (dec_s) begin
        cnt_d[i] = cnt_q[i] - ONE_C;
        vld_d[i] = (cnt_q[i] != ONE_C);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State, forward stage and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        key_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_slot_q   <= '0;
      out_new_q    <= 1'b0;
      slots_used_q <= '0;
      rel_err_q    <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      for (int i = 0; i < SLOTS; i++) begin
        key_q[i] <= key_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      out_valid_q  <= accept_s;
      if (accept_s) begin
        out_slot_q <= acc_idx_s;
      end
      out_new_q    <= accept_s & ~hit_any_s;
      slots_used_q <= popcount(vld_d);
      rel_err_q    <= rel_err_d;
    end
  end

  assign out_pkt    = entry_pkt;
  assign out_valid  = out_valid_q;
  assign out_slot   = out_slot_q;
  assign out_new    = out_new_q;
  assign slots_used = slots_used_q;
  assign rel_err    = rel_err_q;

endmodule

// File: tb/tb_row_arb_cam.sv
// -----------------------------------------------------------------------------
// Testbench for row_arb_cam. A reference model tracks each slot as
// {valid, key, outstanding count} and applies the arbitration / look-up /
// release rules directly. The driver checks the combinational acks and the
// registered status outputs, and pushes the expected forward beat into a
// scoreboard. An independent monitor compares every beat the DUT presents.
// -----------------------------------------------------------------------------
module tb_row_arb_cam;
  import row_arb_cam_pkg::*;

  localparam int SLOTS = 8;
  localparam int DEPTH = 4;
  localparam int SW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ui_pkt_req = 1'b0;
  key_t          ui_key = '0;
  logic          intf_pkt_req = 1'b0;
  key_t          intf_key = '0;
  logic          ui_pkt_ack, intf_pkt_ack;
  pkt_t          entry_pkt = '0;
  pkt_t          out_pkt;
  logic          out_valid;
  logic [SW-1:0] out_slot;
  logic          out_new;
  logic          rel_valid = 1'b0;
  logic [SW-1:0] rel_slot = '0;
  logic [SW:0]   slots_used;
  logic          rel_err;

  row_arb_cam #(.SLOTS(SLOTS), .SLOT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ui_pkt_req(ui_pkt_req), .ui_prio(ui_key.prio), .ui_row_addr(ui_key.row), .ui_bk_addr(ui_key.bk),
    .intf_pkt_req(intf_pkt_req), .intf_prio(intf_key.prio), .intf_row_addr(intf_key.row),
    .intf_bk_addr(intf_key.bk),
    .ui_pkt_ack(ui_pkt_ack), .intf_pkt_ack(intf_pkt_ack),
    .entry_pkt(entry_pkt), .out_pkt(out_pkt), .out_valid(out_valid), .out_slot(out_slot),
    .out_new(out_new), .rel_valid(rel_valid), .rel_slot(rel_slot),
    .slots_used(slots_used), .rel_err(rel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] pkt;
    int          slot;
    logic        nw;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model
  bit          m_vld [SLOTS];
  key_t        m_key [SLOTS];
  int          m_cnt [SLOTS];
  bit          m_err;
  bit          pend_v;
  logic [31:0] pend_pkt;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int m_used();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) n += m_vld[i];
    return n;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < SLOTS; i++) begin
      m_vld[i] = 1'b0;
      m_key[i] = '0;
      m_cnt[i] = 0;
    end
    m_err  = 1'b0;
    pend_v = 1'b0;
    sb.delete();
  endfunction

  function automatic key_t mk_key(int p, int r, int b);
    key_t k;
    k.prio = PRIO_W'(p);
    k.row  = ROW_ADDR_WIDTH'(r);
    k.bk   = BK_ADDR_WIDTH'(b);
    return k;
  endfunction

  function automatic key_t rnd_key();
    return mk_key($urandom_range(0, 1), 'h12 + 'h22 * $urandom_range(0, 2), $urandom_range(0, 2));
  endfunction

  // One clock cycle of stimulus, with model evaluation and ack checks.
  task automatic do_cycle(input logic ur, input key_t uk, input logic ir, input key_t ik,
                          input logic rv, input int rs);
    key_t        k;
    int          hit, fr, slot;
    bit          acc, rel_ok, nw;
    logic [31:0] p;
    @(posedge clk);
    #1;
    check("slots_used", 32'(slots_used), 32'(m_used()));
    check("rel_err", 32'(rel_err), 32'(m_err));
    ui_pkt_req   = ur;
    ui_key       = uk;
    intf_pkt_req = ir;
    intf_key     = ik;
    rel_valid    = rv;
    rel_slot     = SW'(rs);
    entry_pkt    = pend_v ? pend_pkt : $urandom;
    #3;
    k   = ir ? ik : uk;
    hit = -1;
    fr  = -1;
    for (int i = 0; i < SLOTS; i++) if (m_vld[i] && m_key[i] == k) hit = i;
    for (int i = SLOTS - 1; i >= 0; i--) if (!m_vld[i]) fr = i;
    if (!(ur || ir)) acc = 1'b0;
    else if (hit >= 0) acc = (m_cnt[hit] < DEPTH);
    else acc = (fr >= 0);
    check("intf_pkt_ack", 32'(intf_pkt_ack), 32'(acc && ir));
    check("ui_pkt_ack", 32'(ui_pkt_ack), 32'(acc && !ir));
    nw   = (hit < 0);
    slot = nw ? fr : hit;
    // Release is judged on the state before this cycle's accept takes effect.
    rel_ok = rv && m_vld[rs] && (m_cnt[rs] > 0);
    if (rv && !rel_ok) m_err = 1'b1;
    pend_v = acc;
    if (acc) begin
      p        = $urandom;
      pend_pkt = p;
      sb.push_back('{due: cyc + 1, pkt: p, slot: slot, nw: nw});
      if (nw) begin
        m_vld[slot] = 1'b1;
        m_key[slot] = k;
        m_cnt[slot] = 1;
      end else begin
        m_cnt[slot]++;
      end
    end
    if (rel_ok) begin
      m_cnt[rs]--;
      if (m_cnt[rs] == 0) m_vld[rs] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, '0, 1'b0, 0);
  endtask

  // Scoreboard monitor: every presented beat must match the oldest expectation due now.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          check("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_pkt", out_pkt, e.pkt);
          check("out_slot", 32'(out_slot), 32'(e.slot));
          check("out_new", 32'(out_new), 32'(e.nw));
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        check("out_valid_missing", 32'(out_valid), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    key_t k0, ka, kb;
    bit   rv;
    int   rs, st;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_slots_used", 32'(slots_used), 32'd0);
    rst = 1'b0;

    // First allocation, then fill slot 0 to depth and hold the extra request.
    k0 = mk_key(0, 'h12, 2);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, k0, 1'b0, '0, 1'b0, 0);
    do_cycle(1'b1, k0, 1'b0, '0, 1'b1, 0);  // still full this cycle, release lands
    do_cycle(1'b1, k0, 1'b0, '0, 1'b0, 0);  // accepted now
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 0);

    // Fill all slots with distinct keys; the ninth must wait for a free slot.
    for (int i = 0; i < SLOTS; i++) do_cycle(1'b1, mk_key(1, 'h100 + i, 1), 1'b0, '0, 1'b0, 0);
    do_cycle(1'b1, mk_key(1, 'h200, 1), 1'b0, '0, 1'b1, 3);  // release frees slot 3, miss waits
    do_cycle(1'b1, mk_key(1, 'h200, 1), 1'b0, '0, 1'b0, 0);  // allocated to slot 3

    // Simultaneous hit-accept and release on a slot holding one packet.
    do_cycle(1'b1, mk_key(1, 'h101, 1), 1'b0, '0, 1'b1, 1);

    // Retry has strict priority over UI.
    ka = mk_key(0, 'h101, 1);
    kb = mk_key(1, 'h102, 1);
    do_cycle(1'b1, ka, 1'b1, kb, 1'b0, 0);
    idle(2);

    // Randomized traffic: legal releases only, then any slot.
    for (int n = 0; n < 1500; n++) begin
      rv = ($urandom_range(0, 9) < 4);
      rs = $urandom_range(0, SLOTS - 1);
      if (n < 1200 && rv) begin
        st = rs;
        rv = 1'b0;
        for (int j = 0; j < SLOTS; j++) begin
          if (!rv && m_vld[(st + j) % SLOTS] && m_cnt[(st + j) % SLOTS] > 0) begin
            rv = 1'b1;
            rs = (st + j) % SLOTS;
          end
        end
      end
      do_cycle($urandom_range(0, 9) < 7, rnd_key(), $urandom_range(0, 9) < 3, rnd_key(), rv, rs);
    end

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    do_cycle(1'b1, mk_key(1, 'h3ff, 2), 1'b0, '0, 1'b0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_slot", 32'(out_slot), 32'd0);
    check("async_out_new", 32'(out_new), 32'd0);
    check("async_slots_used", 32'(slots_used), 32'd0);
    check("async_rel_err", 32'(rel_err), 32'd0);
    check("async_ui_ack", 32'(ui_pkt_ack), 32'd0);
    ui_pkt_req   = 1'b0;
    intf_pkt_req = 1'b0;
    rel_valid    = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Release on an invalid slot sets the sticky error and changes nothing.
    do_cycle(1'b1, k0, 1'b0, '0, 1'b0, 0);
    do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 5);
    do_cycle(1'b1, k0, 1'b0, '0, 1'b0, 0);
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
